// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: shared op/state encodings, default sizes and TAP TMS prefixes (LSB = first period)
package jtag_seq_pkg;
  typedef enum logic [1:0] {OP_RESET = 2'd0, OP_IR_SCAN = 2'd1, OP_DR_SCAN = 2'd2, OP_RSVD = 2'd3} op_t;
  typedef enum logic [2:0] {IDLE, RST_SEQ, PREFIX, SHIFT, EXIT_UPD, RSP} state_t;
  localparam int IR_WIDTH_DEF = 5;
  localparam int DR_MAX_DEF = 14;
  localparam int RST_HIGH = 5;
  localparam logic [3:0] IR_PREFIX = 4'b0011;
  localparam logic [3:0] DR_PREFIX = 4'b0001;
  localparam int IR_PRE_LEN = 4;
  localparam int DR_PRE_LEN = 3;
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: two-clk TCK period (low then high) while run; rise/fall strobe the edge where TCK goes 0->1 / 1->0
module jtag_tck_gen (
  input  logic clk,
  input  logic nRST,
  input  logic run,
  output logic tck,
  output logic rise,
  output logic fall
);
  assign rise = run & ~tck;
  assign fall = run & tck;
  always_ff @(posedge clk)
    tck <= nRST & run & ~tck;
endmodule

// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: cmd/rsp driven JTAG RESET/IR/DR sequencer; ports clk,nRST, cmd_*, rsp_*, TCK/TMS/TDI/TRST out, TDO in
module jtag_tap_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int NUM_IN = 9,
  parameter int NUM_OUT = 5,
  parameter int IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [3:0]                 cmd_len,
  input  logic [NUM_IN+NUM_OUT-1:0]  cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [NUM_IN+NUM_OUT-1:0]  rsp_data,
  output logic                       rsp_err,
  output logic                       TCK,
  output logic                       TMS,
  output logic                       TDI,
  output logic                       TRST,
  input  logic                       TDO
);
  localparam int DR_MAX = NUM_IN + NUM_OUT;
  localparam int CW = $clog2(DR_MAX + IR_WIDTH + 6);
  typedef logic [DR_MAX-1:0] dr_t;
  state_t state;
  op_t op;
  logic run, rise, fall, tap_known, is_ir, reject;
  logic [CW-1:0] cnt, nxt, len_q, pre_last;
  logic [3:0] pre_q;
  dr_t data_q, cap;
  assign op = op_t'(cmd_op);
  assign cmd_ready = (state == IDLE) & ~rsp_valid;
  assign run = state inside {RST_SEQ, PREFIX, SHIFT, EXIT_UPD};
  assign nxt = cnt + CW'(1);
  assign pre_last = is_ir ? CW'(IR_PRE_LEN - 1) : CW'(DR_PRE_LEN - 1);
  assign reject = (op == OP_RSVD) || (op != OP_RESET && !tap_known) ||
                  (op == OP_DR_SCAN && (cmd_len == 4'd0 || 32'(cmd_len) > DR_MAX));
  jtag_tck_gen u_tck (.clk(clk), .nRST(nRST), .run(run), .tck(TCK), .rise(rise), .fall(fall));
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state <= IDLE;
      TMS <= 1'b1;
      TDI <= 1'b0;
      TRST <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
      tap_known <= 1'b0;
      is_ir <= 1'b0;
      cnt <= '0;
      len_q <= '0;
      pre_q <= '0;
      data_q <= '0;
      cap <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          cnt <= '0;
          cap <= '0;
          data_q <= cmd_data;
          is_ir <= op == OP_IR_SCAN;
          pre_q <= op == OP_IR_SCAN ? IR_PREFIX : DR_PREFIX;
          len_q <= op == OP_IR_SCAN ? CW'(IR_WIDTH) : CW'(cmd_len);
          if (reject) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= '0;
            state <= RSP;
          end else begin
            // every sequence (reset and both prefixes) opens with TMS = 1
            TMS <= 1'b1;
            TRST <= op == OP_RESET;
            state <= op == OP_RESET ? RST_SEQ : PREFIX;
          end
        end
        RST_SEQ: if (fall) begin
          if (cnt == CW'(RST_HIGH)) begin
            TRST <= 1'b0;
            tap_known <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b0;
            rsp_data <= '0;
            state <= RSP;
          end else begin
            cnt <= nxt;
            TMS <= nxt < CW'(RST_HIGH);
          end
        end
        PREFIX: if (fall) begin
          if (cnt == pre_last) begin
            cnt <= '0;
            TDI <= data_q[0];
            data_q <= data_q >> 1;
            TMS <= len_q == CW'(1);
            state <= SHIFT;
          end else begin
            cnt <= nxt;
            TMS <= pre_q[1];
            pre_q <= pre_q >> 1;
          end
        end
        SHIFT: begin
          if (rise)
            cap <= cap | (dr_t'(TDO) << cnt);
          if (fall) begin
            if (nxt == len_q) begin
              cnt <= '0;
              TMS <= 1'b1;
              TDI <= 1'b0;
              state <= EXIT_UPD;
            end else begin
              cnt <= nxt;
              TDI <= data_q[0];
              data_q <= data_q >> 1;
              TMS <= nxt + CW'(1) == len_q;
            end
          end
        end
        EXIT_UPD: if (fall) begin
          if (cnt == CW'(1)) begin
            rsp_valid <= 1'b1;
            rsp_err <= 1'b0;
            rsp_data <= cap;
            state <= RSP;
          end else begin
            cnt <= nxt;
            TMS <= 1'b0;
          end
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: directed bench with IEEE TAP model and TDI->TDO loopback
module tb_jtag_tap_sequencer;
  logic clk = 1'b0, nRST = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0, loop = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_len = 4'd0;
  logic [13:0] cmd_data = '0, rsp_data;
  logic cmd_ready, rsp_valid, rsp_err, TCK, TMS, TDI, TRST, TDO, tdo_tap = 1'b0;
  logic [4:0] ir_sr = '0, ir = '0;
  logic [31:0] tms_log, tdi_log, trst_log;
  int np = 0, ts = 0, errs = 0, checks = 0, e;
  logic ok;
  assign TDO = loop ? TDI : tdo_tap;
  always #5 clk = ~clk;
  jtag_tap_sequencer dut (.clk(clk), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .TCK(TCK), .TMS(TMS),
    .TDI(TDI), .TRST(TRST), .TDO(TDO));
  function automatic int tap_next(input int s, input logic m);
    case (s)
      0: return m ? 0 : 1;
      1: return m ? 2 : 1;
      2: return m ? 9 : 3;
      3, 4: return m ? 5 : 4;
      5: return m ? 8 : 6;
      6: return m ? 7 : 6;
      7: return m ? 8 : 4;
      8, 15: return m ? 2 : 1;
      9: return m ? 0 : 10;
      10, 11: return m ? 12 : 11;
      12: return m ? 15 : 13;
      13: return m ? 14 : 13;
      default: return m ? 15 : 11;
    endcase
  endfunction
  always @(posedge TCK) begin
    if (np < 32) begin
      tms_log[np] = TMS;
      tdi_log[np] = TDI;
      trst_log[np] = TRST;
    end
    np++;
    if (ts == 10) ir_sr = 5'b00001;
    else if (ts == 11) ir_sr = {TDI, ir_sr[4:1]};
    if (ts == 15) ir = ir_sr;
    ts = tap_next(ts, TMS);
  end
  always @(negedge TCK) tdo_tap = (ts == 11) ? ir_sr[0] : 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [1:0] op, input logic [3:0] len, input logic [13:0] data, output int edges);
    np = 0;
    tms_log = '0;
    tdi_log = '0;
    trst_log = '0;
    chk("cmd_ready_before", cmd_ready, 1);
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'b11;
    cmd_len = 4'hF;
    cmd_data = ~data;
    edges = 0;
    while (!rsp_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask
  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_valid, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {TCK, TMS, TDI, TRST, rsp_valid, rsp_err, cmd_ready}, 7'b0100001);
    chk("reset_data", rsp_data, 0);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    run(2'd2, 4'd4, 14'h5, e);
    chk("dr_unknown_edges", e, 0);
    chk("dr_unknown_err", rsp_err, 1);
    chk("dr_unknown_data", rsp_data, 0);
    @(posedge clk);
    #1;
    chk("auto_return", rsp_valid, 0);
    chk("dr_unknown_no_tck", np, 0);
    rsp_ready = 1'b0;
    run(2'd3, 4'd4, 14'h5, e);
    chk("rsvd_edges", e, 0);
    chk("rsvd_err", rsp_err, 1);
    consume();
    run(2'd0, 4'd0, 14'h0, e);
    chk("rst_edges", e, 12);
    chk("rst_periods", np, 6);
    chk("rst_tms", tms_log[5:0], 6'b011111);
    chk("rst_trst", trst_log[5:0], 6'b111111);
    chk("rst_err", rsp_err, 0);
    chk("trst_after", TRST, 0);
    chk("rst_tap_state", ts, 1);
    consume();
    run(2'd1, 4'd0, 14'b10110, e);
    chk("ir_edges", e, 22);
    chk("ir_periods", np, 11);
    chk("ir_tms", tms_log[10:0], 11'h303);
    chk("ir_tdi", tdi_log[8:4], 5'b10110);
    chk("ir_capture", rsp_data, 14'h0001);
    chk("ir_tap_ir", ir, 5'b10110);
    chk("ir_tap_state", ts, 1);
    chk("ir_err", rsp_err, 0);
    consume();
    loop = 1'b1;
    run(2'd2, 4'd14, 14'h2A5C, e);
    chk("dr14_edges", e, 38);
    chk("dr14_periods", np, 19);
    chk("dr14_tms", tms_log[18:0], 19'h30001);
    chk("dr14_tdi", tdi_log[16:3], 14'h2A5C);
    chk("dr14_data", rsp_data, 14'h2A5C);
    chk("dr14_tap_state", ts, 1);
    consume();
    run(2'd2, 4'd1, 14'h3FFF, e);
    chk("dr1_edges", e, 12);
    chk("dr1_tms", tms_log[5:0], 6'b011001);
    chk("dr1_data", rsp_data, 14'h0001);
    consume();
    run(2'd2, 4'd15, 14'h1234, e);
    chk("dr15_edges", e, 0);
    chk("dr15_err", rsp_err, 1);
    chk("dr15_data", rsp_data, 0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 14'h0 || cmd_ready !== 1'b0 || TCK !== 1'b0) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    consume();
    cmd_op = 2'd2;
    cmd_len = 4'd14;
    cmd_data = 14'h1555;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_running", TCK | cmd_ready, 1);
    nRST = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_reset_outs", {TCK, TMS, TDI, TRST, rsp_valid, rsp_err, cmd_ready}, 7'b0100001);
    chk("mid_reset_data", rsp_data, 0);
    nRST = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0 || TCK !== 1'b0) ok = 1'b0;
    end
    chk("mid_no_rsp", ok, 1);
    run(2'd2, 4'd4, 14'h5, e);
    chk("after_abort_edges", e, 0);
    chk("after_abort_err", rsp_err, 1);
    consume();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
